// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states and
// default busy-window lengths, also used by the decoder and stall unit.
package md_ctrl_pkg;

   typedef enum logic [3:0] {
      MdNone  = 4'd0,
      MdMult  = 4'd1,
      MdMultu = 4'd2,
      MdDiv   = 4'd3,
      MdDivu  = 4'd4,
      MdMthi  = 4'd5,
      MdMtlo  = 4'd6,
      MdMfhi  = 4'd7,
      MdMflo  = 4'd8
   } md_op_e;

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } md_state_e;

   localparam int unsigned DefMultCycles = 5;
   localparam int unsigned DefDivCycles  = 10;

   function automatic logic is_arith_op(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd4);
   endfunction

   function automatic logic is_mult_op(input logic [3:0] op);
      return (op == MdMult) || (op == MdMultu);
   endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath working on the latched operands.
// wr_en_o is low for divide-by-zero and for non-arithmetic ops.
module md_alu
   import md_ctrl_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] hi_res_o,
   output logic [31:0] lo_res_o,
   output logic        wr_en_o
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_zero;
   logic               div_ovf;
   logic        [31:0] b_safe;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic        [31:0] quo_u;
   logic        [31:0] rem_u;

   assign prod_s   = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
   assign prod_u   = {32'd0, a_i} * {32'd0, b_i};
   assign div_zero = (b_i == 32'd0);
   assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
   // Keep the divider away from /0 and the one overflowing signed case.
   assign b_safe   = (div_zero || div_ovf) ? 32'd1 : b_i;
   assign quo_s    = $signed(a_i) / $signed(b_safe);
   assign rem_s    = $signed(a_i) % $signed(b_safe);
   assign quo_u    = a_i / b_safe;
   assign rem_u    = a_i % b_safe;

   always_comb begin
      hi_res_o = 32'd0;
      lo_res_o = 32'd0;
      wr_en_o  = 1'b0;
      case (op_i)
         MdMult: begin
            {hi_res_o, lo_res_o} = prod_s;
            wr_en_o = 1'b1;
         end
         MdMultu: begin
            {hi_res_o, lo_res_o} = prod_u;
            wr_en_o = 1'b1;
         end
         MdDiv: begin
            if (div_ovf) begin
               lo_res_o = 32'h8000_0000;
               hi_res_o = 32'd0;
            end else begin
               lo_res_o = quo_s;
               hi_res_o = rem_s;
            end
            wr_en_o = !div_zero;
         end
         MdDivu: begin
            lo_res_o = quo_u;
            hi_res_o = rem_u;
            wr_en_o  = !div_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// E-stage multiply/divide sequencer: fixed-latency busy window, operand latches and
// the HI/LO register pair.
module md_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = DefMultCycles,
   parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op,
   input  logic        md_valid,
   input  logic        flush,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] md_rdata
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   md_state_e   state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        acc;
   logic [31:0] alu_hi;
   logic [31:0] alu_lo;
   logic        alu_wr_en;

   md_alu u_alu (
      .op_i     (op_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .hi_res_o (alu_hi),
      .lo_res_o (alu_lo),
      .wr_en_o  (alu_wr_en)
   );

   assign Busy  = (state_q == StRun);
   assign acc   = md_valid && !flush && !Busy;
   assign Start = acc && is_arith_op(md_op);
   assign HI    = hi_q;
   assign LO    = lo_q;

   always_comb begin
      md_rdata = 32'd0;
      if (md_op == MdMfhi) begin
         md_rdata = hi_q;
      end else if (md_op == MdMflo) begin
         md_rdata = lo_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               state_d = StRun;
               cnt_d   = is_mult_op(md_op) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
               op_d    = md_op;
               a_d     = A;
               b_d     = B;
            end else if (acc && (md_op == MdMthi)) begin
               hi_d = A;
            end else if (acc && (md_op == MdMtlo)) begin
               lo_d = A;
            end
         end
         StRun: begin
            cnt_d = cnt_q - CntW'(1);
            // Last busy cycle: commit the result (skipped on divide-by-zero).
            if (cnt_q == CntW'(1)) begin
               state_d = StIdle;
               if (alu_wr_en) begin
                  hi_d = alu_hi;
                  lo_d = alu_lo;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios then random traffic, all outputs
// compared each cycle against a behavioural HI/LO model.
module tb_md_ctrl;

   localparam int unsigned MultN = 5;
   localparam int unsigned DivN  = 10;

   logic        clk;
   logic        reset;
   logic [3:0]  md_op;
   logic        md_valid;
   logic        flush;
   logic [31:0] A;
   logic [31:0] B;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] md_rdata;

   int n_total;
   int n_bad;

   // Reference model state
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          p_wr;
   int          m_left;

   md_ctrl #(
      .MULT_CYCLES (MultN),
      .DIV_CYCLES  (DivN)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .md_op    (md_op),
      .md_valid (md_valid),
      .flush    (flush),
      .A        (A),
      .B        (B),
      .Start    (Start),
      .Busy     (Busy),
      .HI       (HI),
      .LO       (LO),
      .md_rdata (md_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic model_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sp, sa, sb, q, r;
      longint unsigned up;
      p_wr = 1'b1;
      case (op)
         4'd1: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {p_hi, p_lo} = sp;
            m_left = MultN;
         end
         4'd2: begin
            up = 64'(a) * 64'(b);
            {p_hi, p_lo} = up;
            m_left = MultN;
         end
         4'd3: begin
            m_left = DivN;
            if (b == 32'd0) begin
               p_wr = 1'b0;
            end else begin
               sa   = longint'($signed(a));
               sb   = longint'($signed(b));
               q    = sa / sb;
               r    = sa - q * sb;
               p_lo = q[31:0];
               p_hi = r[31:0];
            end
         end
         default: begin
            m_left = DivN;
            if (b == 32'd0) begin
               p_wr = 1'b0;
            end else begin
               p_lo = a / b;
               p_hi = a % b;
            end
         end
      endcase
   endtask

   task automatic step(input logic [3:0] op, input logic v, input logic f,
                       input logic [31:0] a, input logic [31:0] b);
      bit          acc;
      logic        exp_start;
      logic [31:0] exp_rd;
      md_op    = op;
      md_valid = v;
      flush    = f;
      A        = a;
      B        = b;
      #1;
      acc       = v && !f && (m_left == 0);
      exp_start = acc && (op >= 4'd1) && (op <= 4'd4);
      exp_rd    = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
      check("start", {31'd0, Start}, {31'd0, exp_start});
      check("busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
      check("rdata", md_rdata, exp_rd);
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && p_wr) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (acc) begin
         if (op >= 4'd1 && op <= 4'd4) model_issue(op, a, b);
         else if (op == 4'd5) m_hi = a;
         else if (op == 4'd6) m_lo = a;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      md_valid = 1'b0;
      flush    = 1'b0;
      md_op    = 4'd0;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_left = 0;
      p_wr   = 1'b0;
   endtask

   initial begin
      logic [31:0] ra, rb;
      n_total  = 0;
      n_bad    = 0;
      reset    = 1'b1;
      md_op    = 4'd0;
      md_valid = 1'b0;
      flush    = 1'b0;
      A        = 32'd0;
      B        = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      idle(1);

      // 1: signed mult
      step(4'd1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
      idle(MultN);
      check("t1_hi", HI, 32'hFFFF_FFFF);
      check("t1_lo", LO, 32'hFFFF_FFFA);

      // 2: unsigned mult
      step(4'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2);
      idle(MultN);
      check("t2_hi", HI, 32'h0000_0001);
      check("t2_lo", LO, 32'hFFFF_FFFE);

      // 3: signed div, then divu by zero
      step(4'd3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
      idle(DivN);
      check("t3_lo", LO, 32'hFFFF_FFFD);
      check("t3_hi", HI, 32'hFFFF_FFFF);
      step(4'd4, 1'b1, 1'b0, 32'd7, 32'd0);
      idle(DivN);
      check("t3_dz_lo", LO, 32'hFFFF_FFFD);
      check("t3_dz_hi", HI, 32'hFFFF_FFFF);

      // 4: flush blocks issue; flush during RUN does not
      step(4'd1, 1'b1, 1'b1, 32'd5, 32'd7);
      idle(2);
      check("t4_hi", HI, 32'hFFFF_FFFF);
      step(4'd1, 1'b1, 1'b0, 32'd7, 32'd6);
      step(4'd3, 1'b1, 1'b1, 32'd1, 32'd1);
      step(4'd5, 1'b1, 1'b1, 32'd9, 32'd0);
      idle(MultN - 2);
      check("t4_lo", LO, 32'd42);
      check("t4_hi2", HI, 32'd0);

      // 5: mthi/mfhi/mflo and mtlo while busy
      step(4'd5, 1'b1, 1'b0, 32'h0000_1234, 32'd0);
      step(4'd7, 1'b1, 1'b0, 32'd0, 32'd0);
      step(4'd8, 1'b1, 1'b0, 32'd0, 32'd0);
      check("t5_hi", HI, 32'h0000_1234);
      step(4'd1, 1'b1, 1'b0, 32'd2, 32'd3);
      idle(MultN);
      step(4'd4, 1'b1, 1'b0, 32'd5, 32'd0);
      step(4'd6, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0);
      idle(DivN - 1);
      check("t5_lo", LO, 32'd6);

      // 6: reset in busy cycle 3 of a div
      step(4'd5, 1'b1, 1'b0, 32'h0000_0055, 32'd0);
      step(4'd3, 1'b1, 1'b0, 32'd100, 32'd7);
      idle(2);
      do_reset();
      check("t6_busy", {31'd0, Busy}, 32'd0);
      check("t6_hi", HI, 32'd0);
      check("t6_lo", LO, 32'd0);
      idle(DivN + 2);

      // Signed overflow corner
      step(4'd3, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(DivN);
      check("ovf_lo", LO, 32'h8000_0000);
      check("ovf_hi", HI, 32'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 7))
            0:       ra = 32'h8000_0000;
            1:       ra = $urandom_range(0, 20) - 10;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(0, 20) - 10;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 6) == 0), ra, rb);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
